// File: rtl/music_pkg.sv
// ---------------------------------------------------------------------------
// music_pkg
// Shared constants and types for the music tone generator.
//   - CLK_HZ / CNT_W : system clock the divisor table is built for, and the
//                      width of the half-period counter.
//   - Note-code field positions (octave in [5:4], degree in [3:0]).
//   - Mid-octave half-period divisors, CLK_HZ / (2 * f_note).
//   - FSM state type for the tone generator.
// ---------------------------------------------------------------------------
package music_pkg;

    localparam int CLK_HZ = 50000000;
    localparam int CNT_W  = 18;

    localparam int OCT_MSB = 5;
    localparam int OCT_LSB = 4;
    localparam int DEG_MSB = 3;
    localparam int DEG_LSB = 0;

    // Mid octave (octave code 1) half periods in system clocks.
    localparam int unsigned DIV_C = 95556;
    localparam int unsigned DIV_D = 85131;
    localparam int unsigned DIV_E = 75843;
    localparam int unsigned DIV_F = 71586;
    localparam int unsigned DIV_G = 63776;
    localparam int unsigned DIV_A = 56818;
    localparam int unsigned DIV_B = 50619;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        REST = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/note_lut.sv
// ---------------------------------------------------------------------------
// note_lut
// Combinational note-code to half-period divisor lookup.
//   note_code_i [5:0] : octave [5:4] (0 low, 1 mid, 2 high, 3 invalid),
//                       degree [3:0] (1..7 = C..B, anything else = rest).
//   half_div_o        : half period in system clocks; 0 means rest.
// Low octave doubles the mid-octave divisor, high octave halves it.
// ---------------------------------------------------------------------------
module note_lut #(
    parameter int CNT_W = 18
) (
    input  logic [5:0]       note_code_i,
    output logic [CNT_W-1:0] half_div_o
);
    import music_pkg::*;

    logic [1:0]       oct;
    logic [3:0]       deg;
    logic [CNT_W-1:0] base;

    assign oct = note_code_i[OCT_MSB:OCT_LSB];
    assign deg = note_code_i[DEG_MSB:DEG_LSB];

    always_comb begin
        base = '0;
        case (deg)
            4'd1:    base = CNT_W'(DIV_C);
            4'd2:    base = CNT_W'(DIV_D);
            4'd3:    base = CNT_W'(DIV_E);
            4'd4:    base = CNT_W'(DIV_F);
            4'd5:    base = CNT_W'(DIV_G);
            4'd6:    base = CNT_W'(DIV_A);
            4'd7:    base = CNT_W'(DIV_B);
            default: base = '0;
        endcase
    end

    always_comb begin
        half_div_o = '0;
        case (oct)
            2'd0:    half_div_o = base << 1;
            2'd1:    half_div_o = base;
            2'd2:    half_div_o = base >> 1;
            default: half_div_o = '0;
        endcase
    end

endmodule

// File: rtl/music_tone_gen.sv
// ---------------------------------------------------------------------------
// music_tone_gen
// Latches the song-ROM note code on each beat and drives the buzzer with a
// square wave at that note's pitch. Everything runs on in_clk; the beat clock
// clk_4 is sampled as data.
//   in_clk    : system clock (50 MHz)
//   rst       : asynchronous reset, active low
//   clk_4     : beat clock, asynchronous level input
//   note_code : ROM note code ([5:4] octave, [3:0] degree, [7:6] ignored)
//   beep      : square wave to the buzzer
//   playing   : high while beep is toggling
//   cur_note  : note code latched at the last beat
// Optional feature macro MUSIC_TONE_GAP_EN: when defined, a repeated identical
// note starts with GAP_CYCLES of silence so consecutive notes are audibly
// separated; when undefined, repeats simply restart the tone phase.
// ---------------------------------------------------------------------------
module music_tone_gen #(
    parameter int CLK_HZ     = 50000000,
    parameter int GAP_CYCLES = CLK_HZ / 20,
    parameter int CNT_W      = 18
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       clk_4,
    input  logic [7:0] note_code,
    output logic       beep,
    output logic       playing,
    output logic [7:0] cur_note
);
    import music_pkg::*;

    logic             sync1_q, sync2_q, hist_q;
    logic             beat_rise;
    logic [7:0]       cur_note_q;
    logic [CNT_W-1:0] lut_div;
    logic [CNT_W-1:0] half_div_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beep_q, beep_d;
    state_t           state_q, state_d;

`ifdef MUSIC_TONE_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    note_lut #(.CNT_W(CNT_W)) u_note_lut (
        .note_code_i (note_code[OCT_MSB:DEG_LSB]),
        .half_div_o  (lut_div)
    );

    // Two flops resolve metastability, the third remembers the previous level.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= clk_4;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign beat_rise = sync2_q & ~hist_q;

    // The divisor is taken from the code being latched, so it is ready the
    // cycle after the beat, together with the counter clear.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            cur_note_q <= 8'h00;
            half_div_q <= '0;
        end else if (beat_rise) begin
            cur_note_q <= note_code;
            half_div_q <= lut_div;
        end
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beep_q  <= beep_d;
        end
    end

`ifdef MUSIC_TONE_GAP_EN
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beep_d  = beep_q;
        playing = 1'b0;
`ifdef MUSIC_TONE_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            TONE: begin
                playing = 1'b1;
                // Equality is safe: half_div only changes alongside a counter clear.
                if (cnt_q == half_div_q - CNT_W'(1)) begin
                    cnt_d  = '0;
                    beep_d = ~beep_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef MUSIC_TONE_GAP_EN
            GAP: begin
                cnt_d  = '0;
                beep_d = 1'b0;
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = TONE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
`endif
            default: begin
                cnt_d  = '0;
                beep_d = 1'b0;
            end
        endcase

        // A beat overrides whatever the current state was doing.
        if (beat_rise) begin
            cnt_d  = '0;
            beep_d = 1'b0;
`ifdef MUSIC_TONE_GAP_EN
            gap_d  = '0;
            if (lut_div == '0) begin
                state_d = REST;
            end else if (note_code == cur_note_q) begin
                state_d = GAP;
            end else begin
                state_d = TONE;
            end
`else
            if (lut_div == '0) begin
                state_d = REST;
            end else begin
                state_d = TONE;
            end
`endif
        end
    end

    assign beep     = beep_q;
    assign cur_note = cur_note_q;

endmodule

// File: tb/tb_music_tone_gen.sv
module tb_music_tone_gen;

    localparam int GAP = 200;

    logic       in_clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_4 = 1'b0;
    logic [7:0] note_code = 8'h00;
    logic       beep;
    logic       playing;
    logic [7:0] cur_note;

    int total = 0;
    int bad = 0;
    longint ncyc = 0;

    // Behavioural model state.
    bit         pend_valid = 1'b0;
    longint     pend_t0 = 0;
    logic [7:0] pend_code = 8'h00;
    bit         m_active = 1'b0;
    longint     m_t0 = 0;
    logic [7:0] m_code = 8'h00;
    int         m_div = 0;
    int         m_mode = 0;   // 0 silent, 1 tone, 2 gap-then-tone
    bit         gap_en;

    music_tone_gen #(.GAP_CYCLES(GAP)) dut (
        .in_clk    (in_clk),
        .rst       (rst),
        .clk_4     (clk_4),
        .note_code (note_code),
        .beep      (beep),
        .playing   (playing),
        .cur_note  (cur_note)
    );

    always #5 in_clk = ~in_clk;

    always @(posedge in_clk) ncyc <= ncyc + 1;

    // Half period in clocks straight from the note rules.
    function automatic int model_div(input logic [7:0] code);
        int unsigned tbl [7] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619};
        int oct;
        int deg;
        oct = int'(code[5:4]);
        deg = int'(code[3:0]);
        if (oct == 3 || deg < 1 || deg > 7) return 0;
        if (oct == 0) return int'(tbl[deg-1]) * 2;
        if (oct == 2) return int'(tbl[deg-1]) / 2;
        return int'(tbl[deg-1]);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad < 30)
                $display("FAIL %s at cycle %0d: got %0d want %0d", name, ncyc, act, exp);
        end
    endtask

    task automatic model_reset();
        pend_valid = 1'b0;
        m_active   = 1'b0;
        m_code     = 8'h00;
        m_mode     = 0;
    endtask

    // Raise the beat clock just after an edge; the code is latched 3 edges later.
    task automatic beat_start(input logic [7:0] code, output longint t0);
        @(posedge in_clk);
        #1;
        note_code = code;
        clk_4     = 1'b1;
        t0        = ncyc + 3;
        pend_code = code;
        pend_t0   = t0;
        pend_valid = 1'b1;
        repeat (4) @(posedge in_clk);
        #1;
        clk_4 = 1'b0;
    endtask

    task automatic wait_cyc(input longint n);
        @(negedge in_clk);
        while (ncyc < n) @(negedge in_clk);
    endtask

    // Model compare on every falling edge.
    always @(negedge in_clk) begin
        longint k;
        logic   e_beep;
        logic   e_play;
        if (pend_valid && ncyc >= pend_t0) begin
            pend_valid = 1'b0;
            m_div = model_div(pend_code);
            if (m_div == 0) m_mode = 0;
            else if (gap_en && pend_code == m_code) m_mode = 2;
            else m_mode = 1;
            m_code   = pend_code;
            m_t0     = pend_t0;
            m_active = 1'b1;
        end
        e_beep = 1'b0;
        e_play = 1'b0;
        if (m_active && m_mode != 0) begin
            k = ncyc - m_t0;
            if (m_mode == 2) k = k - GAP;
            if (k >= 0) begin
                e_play = 1'b1;
                e_beep = ((k / m_div) % 2) == 1;
            end
        end
        check("beep", beep, e_beep);
        check("playing", playing, e_play);
        check("cur_note", cur_note, m_code);
    end

    initial begin
        longint t0;
`ifdef MUSIC_TONE_GAP_EN
        gap_en = 1'b1;
`else
        gap_en = 1'b0;
`endif
        model_reset();

        // Reset held with the beat clock toggling.
        for (int i = 0; i < 10; i++) begin
            @(negedge in_clk);
            clk_4 = ~clk_4;
            check("rst_beep", beep, 0);
            check("rst_playing", playing, 0);
            check("rst_cur_note", cur_note, 0);
            check("rst_state_idle", (dut.state_q == music_pkg::IDLE), 1);
        end
        clk_4 = 1'b0;
        repeat (4) @(negedge in_clk);
        rst = 1'b1;
        repeat (5) @(negedge in_clk);
        check("idle_playing", playing, 0);

        // Mid A: 440 Hz, half period 56818.
        beat_start(8'h16, t0);
        wait_cyc(t0);
        check("a_cur_note", cur_note, 8'h16);
        check("a_playing", playing, 1);
        wait_cyc(t0 + 1);
        check("a_half_div", dut.half_div_q, 56818);
        wait_cyc(t0 + 56817);
        check("a_beep_before_toggle", beep, 0);
        wait_cyc(t0 + 56818);
        check("a_beep_after_toggle", beep, 1);
        wait_cyc(t0 + 56900);

        // Asynchronous reset while beep is high.
        @(negedge in_clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_beep", beep, 0);
        check("async_playing", playing, 0);
        check("async_cur_note", cur_note, 0);
        repeat (5) @(negedge in_clk);
        rst = 1'b1;
        repeat (3) @(negedge in_clk);

        // First E after reset plays immediately; the repeat may gap.
        beat_start(8'h13, t0);
        wait_cyc(t0);
        check("e1_playing", playing, 1);
        wait_cyc(t0 + 1);
        check("e1_half_div", dut.half_div_q, 75843);
        wait_cyc(t0 + 300);
        beat_start(8'h13, t0);
        wait_cyc(t0);
`ifdef MUSIC_TONE_GAP_EN
        check("e2_playing_gap", playing, 0);
        wait_cyc(t0 + GAP - 1);
        check("e2_playing_gap_end", playing, 0);
        wait_cyc(t0 + GAP);
        check("e2_playing_after_gap", playing, 1);
`else
        check("e2_playing", playing, 1);
`endif
        wait_cyc(t0 + GAP + 100);

        // Octave shifts.
        beat_start(8'h01, t0);
        wait_cyc(t0 + 1);
        check("low_c_half_div", dut.half_div_q, 191112);
        wait_cyc(t0 + 200);
        beat_start(8'h21, t0);
        wait_cyc(t0 + 1);
        check("high_c_half_div", dut.half_div_q, 47778);
        check("high_c_playing", playing, 1);
        wait_cyc(t0 + 200);

        // Rest degree and invalid octave.
        beat_start(8'h10, t0);
        wait_cyc(t0 + 1);
        check("rest_half_div", dut.half_div_q, 0);
        check("rest_playing", playing, 0);
        check("rest_cur_note", cur_note, 8'h10);
        wait_cyc(t0 + 300);
        beat_start(8'h35, t0);
        wait_cyc(t0 + 1);
        check("inv_half_div", dut.half_div_q, 0);
        check("inv_playing", playing, 0);
        wait_cyc(t0 + 300);

        // Repeated rest stays silent; then a high-octave B.
        beat_start(8'h35, t0);
        wait_cyc(t0 + 50);
        check("rest2_playing", playing, 0);
        beat_start(8'h27, t0);
        wait_cyc(t0 + 1);
        check("high_b_half_div", dut.half_div_q, 25309);
        wait_cyc(t0 + 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
